// File: rtl/i2s_clk_gen_top.sv
// I2S transmit clock generator: MCLK, SCLK and LRCLK taken straight from the
// bits of one free-running binary counter on the system clock.
module i2s_clk_gen_top #(
  parameter int MCLK_DIV  = 8,
  parameter int SCLK_DIV  = 4,
  parameter int LRCLK_DIV = 64
) (
  input  logic clk,
  input  logic reset,
  output logic tx_mclk,
  output logic tx_sclk,
  output logic tx_lrclk
);

  localparam int TOTAL_DIV = MCLK_DIV * SCLK_DIV * LRCLK_DIV;
  localparam int N         = $clog2(TOTAL_DIV);
  localparam int MCLK_BIT  = $clog2(MCLK_DIV) - 1;
  localparam int SCLK_BIT  = $clog2(MCLK_DIV * SCLK_DIV) - 1;
  localparam int LRCLK_BIT = N - 1;

  // Dividers must be powers of two so that each clock is a single counter bit.
  if ((MCLK_DIV < 2) || ((MCLK_DIV & (MCLK_DIV - 1)) != 0)) begin : g_bad_mclk_div
    $error("MCLK_DIV must be a power of two and at least 2");
  end
  if ((SCLK_DIV < 1) || ((SCLK_DIV & (SCLK_DIV - 1)) != 0)) begin : g_bad_sclk_div
    $error("SCLK_DIV must be a power of two and at least 1");
  end
  if ((LRCLK_DIV < 2) || ((LRCLK_DIV & (LRCLK_DIV - 1)) != 0)) begin : g_bad_lrclk_div
    $error("LRCLK_DIV must be a power of two and at least 2");
  end

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;

  // Next count: plain increment, natural wrap from all-ones back to zero.
  always_comb begin
    cnt_d = cnt_q + N'(1);
  end

  // Counter register; reset restarts every clock phase from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Each output is a register bit, so edges are glitch-free and phase-aligned:
  // a higher bit can only toggle when every lower bit wraps to zero.
  assign tx_mclk  = cnt_q[MCLK_BIT];
  assign tx_sclk  = cnt_q[SCLK_BIT];
  assign tx_lrclk = cnt_q[LRCLK_BIT];

endmodule

// File: tb/tb_i2s_clk_gen_top.sv
// Bench for i2s_clk_gen_top: clocks since reset release drive a modulo-based
// model of the three clocks, checked every cycle, plus pinned timing points.
module tb_i2s_clk_gen_top;

  localparam int MD  = 8;
  localparam int SD  = 4;
  localparam int LD  = 64;
  localparam int P_M = MD;
  localparam int P_S = MD * SD;
  localparam int P_L = MD * SD * LD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_mclk, tx_sclk, tx_lrclk;

  int checks = 0;
  int errors = 0;

  // Model state: clocks elapsed since the last sampled reset.
  int m = 0;
  bit mvalid = 1'b0;

  // Phase-check state.
  bit prv_ok = 1'b0;
  logic prv_m, prv_s, prv_l;
  int sr = 0;

  int k = 0;

  always #5 clk = ~clk;

  i2s_clk_gen_top #(
    .MCLK_DIV (MD),
    .SCLK_DIV (SD),
    .LRCLK_DIV(LD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_mclk (tx_mclk),
    .tx_sclk (tx_sclk),
    .tx_lrclk(tx_lrclk)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A clock of period per is low for the first half of each period after release.
  function automatic bit exp_bit(input int mm, input int per);
    return (mm % per) >= (per / 2);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m <= 0;
      mvalid <= 1'b1;
    end else if (mvalid) begin
      m <= m + 1;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("mclk_model", tx_mclk, exp_bit(m, P_M));
      chk("sclk_model", tx_sclk, exp_bit(m, P_S));
      chk("lrclk_model", tx_lrclk, exp_bit(m, P_L));
      if (m == 0) begin
        sr = 0;
      end else if (prv_ok) begin
        if (tx_sclk !== prv_s)
          chk("sclk_edge_on_mclk_fall", {prv_m, tx_mclk}, 2'b10);
        if (tx_sclk === 1'b1 && prv_s === 1'b0)
          sr++;
        if (tx_lrclk !== prv_l) begin
          chk("lrclk_edge_on_sclk_fall", {prv_s, tx_sclk}, 2'b10);
          chk("sclk_rises_per_half", sr, LD / 2);
          sr = 0;
        end
      end
      prv_m  = tx_mclk;
      prv_s  = tx_sclk;
      prv_l  = tx_lrclk;
      prv_ok = 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  // Pinned timing points after a release, counted in clocks since release.
  task automatic pin_release_timing();
    run_to(3);    chk("mclk_low_at_3", tx_mclk, 0);
    run_to(4);    chk("mclk_rise_at_4", tx_mclk, 1);
    run_to(7);    chk("mclk_high_at_7", tx_mclk, 1);
    run_to(8);    chk("mclk_fall_at_8", tx_mclk, 0);
    run_to(12);   chk("mclk_rise_at_12", tx_mclk, 1);
    run_to(15);   chk("sclk_low_at_15", tx_sclk, 0);
    run_to(16);   chk("sclk_rise_at_16", tx_sclk, 1);
    run_to(32);   chk("sclk_fall_at_32", tx_sclk, 0);
  endtask

  initial begin
    // Reset held for five clocks: everything stays low.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_mclk", tx_mclk, 0);
      chk("hold_sclk", tx_sclk, 0);
      chk("hold_lrclk", tx_lrclk, 0);
    end
    reset = 1'b0;
    k = 0;

    pin_release_timing();
    run_to(1023); chk("lrclk_low_at_1023", tx_lrclk, 0);
    run_to(1024); chk("lrclk_rise_at_1024", tx_lrclk, 1);
    run_to(1500); chk("lrclk_high_at_1500", tx_lrclk, 1);

    // Mid-operation reset sampled while the count is 1500.
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_mclk", tx_mclk, 0);
    chk("midrst_sclk", tx_sclk, 0);
    chk("midrst_lrclk", tx_lrclk, 0);
    reset = 1'b0;
    k = 0;
    pin_release_timing();
    run_to(1024); chk("lrclk_rise_after_midrst", tx_lrclk, 1);
    run_to(2047); chk("lrclk_high_at_2047", tx_lrclk, 1);
    run_to(2048); chk("lrclk_fall_at_wrap", tx_lrclk, 0);
    run_to(3072); chk("lrclk_rise_at_3072", tx_lrclk, 1);
    run_to(4096); chk("lrclk_fall_at_4096", tx_lrclk, 0);
    run_to(4300);

    // Random run lengths and reset pulses; the per-cycle model covers them.
    for (int r = 0; r < 8; r++) begin
      int run_len;
      int rst_len;
      run_len = $urandom_range(3000, 1);
      rst_len = $urandom_range(4, 1);
      k = 0;
      run_to(run_len);
      reset = 1'b1;
      for (int j = 0; j < rst_len; j++) @(negedge clk);
      reset = 1'b0;
    end

    k = 0;
    run_to(4200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
